// File: rtl/parity_frame_serializer.sv
// Serializes a DATA_W-bit word LSB first and appends a parity bit accumulated bit-serially.
// Optional macro PARITY_SEL_EN adds a par_even input that selects even parity at accept time.
module parity_frame_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PARITY_SEL_EN
    input  logic              par_even,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic              tx_bit,
    output logic              tx_is_par,
    output logic              frame_done,
    output logic              busy
);

    // A 1-bit counter is kept for DATA_W=1 so the vector stays legal.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              acc, acc_nxt;
    logic              done_nxt;
    logic              seed;

`ifdef PARITY_SEL_EN
    assign seed = ~par_even;
`else
    assign seed = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            acc        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        done_nxt  = 1'b0;
        in_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_bit    = 1'b0;
        tx_is_par = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_nxt = in_data;
                    cnt_nxt   = '0;
                    acc_nxt   = seed;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                tx_valid = 1'b1;
                tx_bit   = shreg[0];
                if (tx_ready) begin
                    acc_nxt   = acc ^ shreg[0];
                    shreg_nxt = shreg >> 1;
                    if (cnt == LAST) begin
                        state_nxt = PARITY;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                tx_valid  = 1'b1;
                tx_bit    = acc;
                tx_is_par = 1'b1;
                if (tx_ready) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench for parity_frame_serializer with DATA_W=8; even-parity case only when PARITY_SEL_EN is defined.
module tb_parity_frame_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_ready;
    logic       tx_valid;
    logic       tx_bit;
    logic       tx_is_par;
    logic       frame_done;
    logic       busy;
`ifdef PARITY_SEL_EN
    logic       par_even;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    parity_frame_serializer #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PARITY_SEL_EN
        .par_even   (par_even),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_bit     (tx_bit),
        .tx_is_par  (tx_is_par),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame with tx_ready high except for an optional stall window.
    // stall_k: beat index to stall on; ignore_k: beat on which to pulse in_valid with 8'hFF;
    // abort_k: beat on which rst is asserted and the frame abandoned. -1 disables each.
    task automatic send(input logic [7:0] data, input logic exp_par, input int stall_k,
                        input int stall_len, input int ignore_k, input int abort_k);
        in_valid = 1'b1;
        in_data  = data;
        chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bit%0d_valid", k), {31'd0, tx_valid}, 32'd1);
            chk($sformatf("bit%0d_val", k), {31'd0, tx_bit}, {31'd0, data[k]});
            chk($sformatf("bit%0d_is_par", k), {31'd0, tx_is_par}, 32'd0);
            chk($sformatf("bit%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            if (k == abort_k) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            if (k == ignore_k) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
                step();
                in_valid = 1'b0;
                continue;
            end
            if (k == stall_k) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk($sformatf("stall%0d_bit", s), {31'd0, tx_bit}, {31'd0, data[k]});
                    chk($sformatf("stall%0d_valid", s), {31'd0, tx_valid}, 32'd1);
                end
                tx_ready = 1'b1;
            end
            step();
        end
        chk("par_valid", {31'd0, tx_valid}, 32'd1);
        chk("par_is_par", {31'd0, tx_is_par}, 32'd1);
        chk("par_val", {31'd0, tx_bit}, {31'd0, exp_par});
        chk("par_no_done", {31'd0, frame_done}, 32'd0);
        step();
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("done_idle_busy", {31'd0, busy}, 32'd0);
        chk("done_idle_valid", {31'd0, tx_valid}, 32'd0);
        step();
        chk("done_clear", {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tx_ready = 1'b1;
`ifdef PARITY_SEL_EN
        par_even = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_tx_bit", {31'd0, tx_bit}, 32'd0);
        chk("rst_is_par", {31'd0, tx_is_par}, 32'd0);

        send(8'hA5, 1'b1, -1, 0, -1, -1);
        send(8'h07, 1'b0, -1, 0, -1, -1);
        send(8'h00, 1'b1, -1, 0, -1, -1);
        send(8'hFF, 1'b1, -1, 0, -1, -1);
        send(8'h3C, 1'b1, 3, 3, -1, -1);

        send(8'hC3, 1'b1, -1, 0, -1, 4);
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_no_done", {31'd0, frame_done}, 32'd0);
        step();
        chk("abort_no_done2", {31'd0, frame_done}, 32'd0);
        send(8'h01, 1'b0, -1, 0, -1, -1);

        send(8'hA5, 1'b1, -1, 0, 2, -1);
        chk("ignored_stays_idle", {31'd0, busy}, 32'd0);

`ifdef PARITY_SEL_EN
        par_even = 1'b1;
        send(8'hA5, 1'b0, -1, 0, -1, -1);
        par_even = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_serializer.md
Name: parity_frame_serializer

Overview:
- Sequences a parallel data word onto a 1-bit serial link and appends an odd-parity bit.
- Output frame: DATA_W data bits, LSB first, followed by one parity bit.
- Parity is accumulated bit-serially as each bit leaves, not computed combinationally up front.
- Sits between a parallel producer and a serial consumer; uses a valid/ready handshake on both sides.

Parameters:
- DATA_W, 8: data word width in bits. Legal range 1..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  DATA_W  parallel word to serialize.
- in_ready  output  1  block can accept a word this cycle.
- tx_ready  input  1  consumer accepts tx_bit this cycle.
- tx_valid  output  1  tx_bit is valid.
- tx_bit  output  1  current serial bit.
- tx_is_par  output  1  current beat is the parity bit.
- frame_done  output  1  one-cycle pulse after the parity beat is accepted.
- busy  output  1  a frame is in flight (state is not IDLE).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values (rst high at a clock edge):
  - state=IDLE.
  - in_ready=1, tx_valid=0, tx_bit=0, tx_is_par=0, frame_done=0, busy=0.
  - Shift register, bit counter and parity accumulator all cleared.
- Reset mid-frame: the frame is abandoned and no frame_done is issued. Next cycle the block is in IDLE.
- State IDLE:
  - in_ready=1, tx_valid=0.
  - Accept occurs when in_valid && in_ready. On accept: latch in_data into the shift register, set bit counter=0, set parity accumulator acc=1 (odd seed), go to SHIFT.
  - in_valid while not in IDLE is ignored. The producer must hold the word until it is accepted.
- State SHIFT:
  - Outputs: tx_valid=1, tx_bit=shreg[0], tx_is_par=0, in_ready=0.
  - Beat accepted (tx_valid && tx_ready): acc <= acc ^ shreg[0]; shift right by one; counter++.
  - On the beat where counter==DATA_W-1, go to PARITY.
  - tx_ready low: state, tx_bit, acc and counter all hold. Stalls of any length are legal.
- State PARITY:
  - Outputs: tx_valid=1, tx_bit=acc, tx_is_par=1.
  - Beat accepted: go to IDLE, frame_done=1 for exactly the next cycle. Otherwise hold.
- Latency and throughput:
  - Word accepted at edge N → first data bit valid in cycle N+1.
  - With tx_ready tied high, the parity bit is valid at cycle N+DATA_W+1.
  - Frame is DATA_W+1 beats. One IDLE cycle is guaranteed between frames, so peak throughput is one word per DATA_W+2 cycles.
- Parity rule: popcount(data bits) + parity bit is odd, i.e. parity = ~^in_data (as latched).
- DATA_W=1: SHIFT lasts one beat, then PARITY.
- Counter width is clog2(DATA_W). The counter never exceeds DATA_W-1 and does not wrap within a frame.
- busy = (state != IDLE). tx_valid and in_ready are never high together.

Optional Feature:
- Macro: PARITY_SEL_EN.
- Defined:
  - Adds input port par_even (1 bit), sampled at accept time.
  - par_even=1 seeds acc=0 (even parity); par_even=0 seeds acc=1 (odd parity).
  - Changing par_even mid-frame has no effect on the frame in flight.
- Undefined: no par_even port; parity is always odd.

Test Plan:
- Reset then idle, in_valid=0 → in_ready=1, tx_valid=0, busy=0, frame_done=0.
- in_data=8'hA5, tx_ready=1 → tx_bit sequence 1,0,1,0,0,1,0,1, then parity 1 with tx_is_par=1; frame_done pulses 1 cycle later; 10 cycles from accept to frame_done.
- in_data=8'h07 → parity 0. in_data=8'h00 → parity 1. in_data=8'hFF → parity 1.
- in_data=8'h3C with tx_ready low for 3 cycles after the 4th bit → tx_bit holds at 1 (bit 3) during the stall, the sequence resumes unchanged, parity=1.
- Assert rst during the 5th data beat → next cycle IDLE, tx_valid=0, no frame_done. A new word 8'h01 then serializes correctly with parity 0.
- in_valid pulsed with 8'hFF during a busy frame → ignored; the current frame's bits and parity are unchanged. With PARITY_SEL_EN defined and par_even=1, 8'hA5 → parity 0.
